a2d_sched: RTL and testbench

A2D_SCHED -- requirements
Module: a2d_sched

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/a2d_rnd_tmr.sv | 29 ++
 rtl/a2d_sched.sv | 133 +++++++++++++
 tb/tb_a2d_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the A2D round scheduler and its round timer.
package seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WAIT_C = 3'd2,
    ST_GAP    = 3'd3,
    ST_READ   = 3'd4,
    ST_WAIT_R = 3'd5
  } state_t;

  localparam logic [2:0]  CH_LFT   = 3'd0;
  localparam logic [2:0]  CH_RGHT  = 3'd4;
  localparam logic [2:0]  CH_STEER = 3'd5;
  localparam logic [2:0]  CH_BATT  = 3'd6;
  localparam logic [1:0]  LAST_IDX = 2'd3;

  // Command word layout: {2'b00, channel[2:0], 11'h000}
  localparam logic [1:0]  CMD_HDR  = 2'b00;
  localparam logic [10:0] CMD_PAD  = 11'h000;

  localparam int          TMR_W    = 21;
  localparam logic [TMR_W-1:0] TC_FAST = 21'd4095;
  localparam logic [TMR_W-1:0] TC_SLOW = 21'h1FFFFF;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {CMD_HDR, ch, CMD_PAD};
  endfunction

  function automatic logic [2:0] idx2ch(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_LFT;
      2'd1:    return CH_RGHT;
      2'd2:    return CH_STEER;
      default: return CH_BATT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_rnd_tmr.sv
// Saturating round timer: counts up from a clear, holds at terminal count (full).
module a2d_rnd_tmr
  import seg_pkg::*;
#(
  parameter logic FAST_SIM = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_full
);

  localparam logic [TMR_W-1:0] TC = FAST_SIM ? TC_FAST : TC_SLOW;

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != TC) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_full = (r_cnt == TC);

endmodule

// File: rtl/a2d_sched.sv
// Round scheduler: converts ch0/4/5/6 via two SPI transactions each, then pulses vld.
// SPI handshake: wrt is a one-clk request with cmd held until done; done is a
// one-clk completion (rsp valid) and is only honoured while awaiting it.
module a2d_sched
  import seg_pkg::*;
#(
  parameter logic FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rsp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output state_t      o_dbg_state
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_idx;
  logic [15:0] r_cmd;
  logic [11:0] r_lft;
  logic [11:0] r_rght;
  logic [11:0] r_steer;
  logic [11:0] r_batt;
  logic        r_vld;
  logic        w_full;
  logic        w_start;
  logic        w_cap;
  logic        w_wrt;
  logic        w_last;
  logic [3:0]  w_unused_rsp;

  assign w_unused_rsp = rsp[15:12];
  assign w_last       = (r_idx == LAST_IDX);

  a2d_rnd_tmr #(
    .FAST_SIM (FAST_SIM)
  ) u_tmr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_start),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cap       = 1'b0;
    w_wrt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trig || w_full) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        w_wrt       = 1'b1;
        w_state_nxt = ST_WAIT_C;
      end
      ST_WAIT_C: begin
        if (done) w_state_nxt = ST_GAP;
      end
      ST_GAP: w_state_nxt = ST_READ;
      ST_READ: begin
        w_wrt       = 1'b1;
        w_state_nxt = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (done) begin
          w_cap       = 1'b1;
          w_state_nxt = w_last ? ST_IDLE : ST_CMD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Results live until the same channel is captured again in a later round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_cmd   <= 16'h0000;
      r_lft   <= 12'h000;
      r_rght  <= 12'h000;
      r_steer <= 12'h000;
      r_batt  <= 12'h000;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= w_cap && w_last;
      if (w_start) begin
        r_idx <= 2'd0;
        r_cmd <= mk_cmd(CH_LFT);
      end else if (w_cap && !w_last) begin
        r_idx <= r_idx + 2'd1;
        r_cmd <= mk_cmd(idx2ch(r_idx + 2'd1));
      end
      if (w_cap) begin
        case (r_idx)
          2'd0:    r_lft   <= rsp[11:0];
          2'd1:    r_rght  <= rsp[11:0];
          2'd2:    r_steer <= rsp[11:0];
          default: r_batt  <= rsp[11:0];
        endcase
      end
    end
  end

  assign wrt         = w_wrt;
  assign cmd         = r_cmd;
  assign lft_ld      = r_lft;
  assign rght_ld     = r_rght;
  assign steer_pot   = r_steer;
  assign batt        = r_batt;
  assign vld         = r_vld;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched: SPI responder model, wrt/vld monitor, directed rounds.
module tb_a2d_sched;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rsp = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        vld;
  state_t      dbg_state;

  always #5 clk = ~clk;

  a2d_sched #(
    .FAST_SIM (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig        (trig),
    .wrt         (wrt),
    .cmd         (cmd),
    .done        (done),
    .rsp         (rsp),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .steer_pot   (steer_pot),
    .batt        (batt),
    .vld         (vld),
    .o_dbg_state (dbg_state)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [47:0] exp_res_q[$];
  logic [15:0] rsp_tbl[4];
  logic [15:0] cmd_seq[8];
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  int          cyc = 0;
  int          spur_req = 0;
  int          spur_ack = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch_slot(input logic [2:0] ch);
    case (ch)
      3'd4:    return 1;
      3'd5:    return 2;
      3'd6:    return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // SPI responder: done 3 negedges after wrt; first transaction returns junk.
  int          spi_cnt = 0;
  logic        spi_busy = 1'b0;
  logic        spi_second = 1'b0;
  logic [15:0] spi_cmd = 16'h0000;
  always @(negedge clk) begin
    done = 1'b0;
    if (!rst_n) begin
      spi_busy   = 1'b0;
      spi_second = 1'b0;
      spi_cnt    = 0;
    end else if (wrt) begin
      spi_busy = 1'b1;
      spi_cnt  = 3;
      spi_cmd  = cmd;
    end else if (spi_busy) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        chk("cmd_held", {32'h0, cmd}, {32'h0, spi_cmd});
        done       = 1'b1;
        rsp        = spi_second ? rsp_tbl[ch_slot(spi_cmd[13:11])] : 16'hDEAD;
        spi_second = !spi_second;
        spi_busy   = 1'b0;
      end
    end else if (spur_req != spur_ack) begin
      done = 1'b1;
      rsp  = 16'hFFFF;
      spur_ack++;
    end
  end

  // Monitor: every wrt and vld must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wrt) begin
        wrt_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wrt: got cmd %h, expected no wrt (t=%0t)", cmd, $time);
        end else begin
          chk("cmd", {32'h0, cmd}, {32'h0, exp_q.pop_front()});
        end
      end
      if (vld) begin
        vld_cnt++;
        if (exp_res_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_vld: got vld, expected none (t=%0t)", $time);
        end else begin
          chk("results", {lft_ld, rght_ld, steer_pot, batt}, exp_res_q.pop_front());
        end
      end
    end
  end

  task automatic push_round(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3,
                            input logic [47:0] exp_res, input int n);
    rsp_tbl = '{r0, r1, r2, r3};
    for (int i = 0; i < n; i++) exp_q.push_back(cmd_seq[i]);
    if (n == 8) exp_res_q.push_back(exp_res);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    int k;
    k = 0;
    while (!vld && k < 300) begin
      tick(1);
      k++;
    end
    if (k >= 300) chk(name, 48'd0, 48'd1);
    tick(1);
  endtask

  task automatic wait_cond(input state_t s, input logic [15:0] c, input logic need_done,
                           input string name);
    int k;
    k = 0;
    while (!(dbg_state == s && cmd == c && (!need_done || done)) && k < 300) begin
      tick(1);
      k++;
    end
    if (k >= 300) chk(name, 48'd0, 48'd1);
  endtask

  task automatic wait_wrt(input string name);
    int k;
    k = 0;
    while (!wrt && k < 5000) begin
      tick(1);
      k++;
    end
    if (k >= 5000) chk(name, 48'd0, 48'd1);
  endtask

  int w0;
  int v0;

  initial begin
    cmd_seq = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                16'h2800, 16'h2800, 16'h3000, 16'h3000};
    rsp_tbl = '{16'h0, 16'h0, 16'h0, 16'h0};
    tick(3);
    chk("rst_wrt", {47'h0, wrt}, 48'd0);
    chk("rst_vld", {47'h0, vld}, 48'd0);
    chk("rst_cmd", {32'h0, cmd}, 48'd0);
    chk("rst_results", {lft_ld, rght_ld, steer_pot, batt}, 48'd0);
    chk("rst_state", {45'h0, dbg_state}, {45'h0, ST_IDLE});
    rst_n = 1'b1;
    tick(3);
    chk("no_self_start", {45'h0, dbg_state}, {45'h0, ST_IDLE});

    // Basic round
    w0 = wrt_cnt; v0 = vld_cnt;
    push_round(16'h0ABC, 16'h0123, 16'h0456, 16'h0789, 48'hABC_123_456_789, 8);
    pulse_trig();
    wait_vld("round_a_timeout");
    tick(10);
    chk("round_a_wrt_count", wrt_cnt - w0, 48'd8);
    chk("round_a_vld_count", vld_cnt - v0, 48'd1);

    // Upper response bits are dropped
    push_round(16'hF111, 16'hE222, 16'hD333, 16'hCFFF, 48'h111_222_333_FFF, 8);
    pulse_trig();
    wait_vld("round_b_timeout");

    // trig in WAIT_R of ch4 is ignored
    v0 = vld_cnt; w0 = wrt_cnt;
    push_round(16'h0001, 16'h0002, 16'h0003, 16'h0004, 48'h001_002_003_004, 8);
    pulse_trig();
    wait_cond(ST_WAIT_R, 16'h2000, 1'b0, "wait_r_ch4_timeout");
    pulse_trig();
    wait_vld("round_c_timeout");
    tick(20);
    chk("round_c_vld_count", vld_cnt - v0, 48'd1);
    chk("round_c_wrt_count", wrt_cnt - w0, 48'd8);

    // trig coincident with final done
    v0 = vld_cnt;
    push_round(16'h0A5A, 16'h05A5, 16'h0F0F, 16'h00F0, 48'hA5A_5A5_F0F_0F0, 8);
    pulse_trig();
    wait_cond(ST_WAIT_R, 16'h3000, 1'b1, "final_done_timeout");
    pulse_trig();
    wait_vld("round_d_timeout");
    tick(20);
    chk("round_d_vld_count", vld_cnt - v0, 48'd1);

    // Spurious done in IDLE
    w0 = wrt_cnt;
    spur_req++;
    tick(6);
    chk("spur_results", {lft_ld, rght_ld, steer_pot, batt}, 48'hA5A_5A5_F0F_0F0);
    chk("spur_state", {45'h0, dbg_state}, {45'h0, ST_IDLE});
    chk("spur_wrt_count", wrt_cnt - w0, 48'd0);

    // Reset during WAIT_C of ch5
    push_round(16'h0111, 16'h0222, 16'h0333, 16'h0444, 48'h0, 5);
    pulse_trig();
    wait_cond(ST_WAIT_C, 16'h2800, 1'b0, "wait_c_ch5_timeout");
    rst_n = 1'b0;
    tick(1);
    chk("midrst_results", {lft_ld, rght_ld, steer_pot, batt}, 48'd0);
    chk("midrst_cmd", {32'h0, cmd}, 48'd0);
    chk("midrst_wrt", {47'h0, wrt}, 48'd0);
    chk("midrst_state", {45'h0, dbg_state}, {45'h0, ST_IDLE});
    chk("midrst_q_empty", exp_q.size(), 48'd0);
    rst_n = 1'b1;
    tick(2);
    push_round(16'h0321, 16'h0654, 16'h0987, 16'h0CBA, 48'h321_654_987_CBA, 8);
    pulse_trig();
    wait_vld("round_f_timeout");

    // Timer-driven rounds
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    push_round(16'h0ABC, 16'h0123, 16'h0456, 16'h0789, 48'hABC_123_456_789, 8);
    wait_wrt("tmr_first_timeout");
    chk("tmr_first_start", cyc, 48'd4096);
    wait_vld("tmr_round1_timeout");
    push_round(16'h0BCD, 16'h0234, 16'h0567, 16'h089A, 48'hBCD_234_567_89A, 8);
    wait_wrt("tmr_second_timeout");
    chk("tmr_second_start", cyc, 48'd8192);
    wait_vld("tmr_round2_timeout");
    tick(5);
    chk("end_cmd_q_empty", exp_q.size(), 48'd0);
    chk("end_res_q_empty", exp_res_q.size(), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
